frame_transmitter: RTL and testbench
====================================

Name: frame_transmitter

Overview:
Upstream neighbour of frame_receiver. It accepts payload bytes from a producer over a valid/ready handshake and frames them. Each frame goes out as one SOF delimiter, the payload bytes, then one FCS byte. A running CRC-8 (poly 0x07, init 0x00) is driven alongside each payload byte, so the downstream receiver can compare it against its own computation. A programmable inter-frame gap is enforced before the next frame.

Parameters:
SOF_BYTE, 8'h7E, delimiter byte emitted at the start of every frame; excluded from the CRC
MAX_LEN, 64, maximum payload bytes per frame (range 1..255)
IFG_CYCLES, 4, idle cycles forced after the FCS byte (range 1..15)

Ports:
clk  in  1  system clock; all state changes on the rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
in_data  in  8  payload byte from the producer
in_valid  in  1  in_data is valid
in_last  in  1  current byte is the last payload byte of the frame
in_ready  out  1  transmitter accepts in_data this cycle
frame_data  out  8  byte sent to frame_receiver
frame_valid  out  1  frame_data is valid this cycle
frame_sof  out  1  frame_data is the SOF delimiter
frame_eof  out  1  frame_data is the FCS byte
crc_out  out  8  running CRC over the payload bytes up to and including frame_data
err_oversize  out  1  one-cycle pulse when a frame is truncated at MAX_LEN
tx_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE.
  - All outputs = 0.
  - CRC register = 0x00; byte counter = 0; gap counter = 0.
- All outputs are registered.
  - A byte accepted in cycle N appears on frame_data in cycle N+1.
  - A transfer occurs when in_valid && in_ready.
- in_ready is combinational from state: high only in DATA. It does not depend on in_valid.
- FSM:
  - IDLE: when in_valid=1, go to SOF. No byte is consumed in this cycle.
  - SOF: for one cycle drive frame_data=SOF_BYTE, frame_valid=1, frame_sof=1, crc_out=0x00. Clear the CRC and the byte counter. Next state is DATA.
  - DATA, transfer occurs: drive frame_data=in_data and frame_valid=1. Set crc_next = crc8(crc, in_data) and crc_out = crc_next. Increment the counter.
    - If in_last=1, or the counter reaches MAX_LEN, go to FCS.
    - If the counter reached MAX_LEN with in_last=0, also pulse err_oversize for 1 cycle, registered with the final payload byte.
  - DATA, no transfer: frame_valid=0 (bubble). CRC and counter hold. crc_out holds its last value.
  - FCS: for one cycle drive frame_data = final CRC, crc_out = final CRC, frame_valid=1, frame_eof=1. Go to GAP and load the gap counter with IFG_CYCLES.
  - GAP: frame_valid=0. Decrement the counter each cycle; at 0 go to IDLE.
- crc8: bitwise MSB-first, poly x^8+x^2+x+1, no reflection, no final XOR. Width is 8 bits throughout.
- frame_sof and frame_eof are never high together. Both are 0 whenever frame_valid=0.
- Boundary conditions:
  - A single-byte frame (in_last on the first byte) is legal: SOF, 1 byte, FCS.
  - in_valid held high through GAP: the next frame starts at the first IDLE cycle. The minimum spacing between FCS and the next SOF is IFG_CYCLES+1 idle cycles.
  - After MAX_LEN truncation, the producer's leftover bytes up to and including in_last begin a new frame after the gap. No special discard is performed.
  - Reset mid-frame aborts immediately. No FCS is emitted, and the next frame begins with SOF.
  - in_last while in_valid=0 is ignored.

Decomposition:
- Shared package frame_pkg holds:
  - the CRC8_POLY = 8'h07 and CRC8_INIT = 8'h00 constants;
  - SOF_BYTE;
  - the state enumeration;
  - a crc8_byte(crc, data) function.
- frame_receiver imports the same package so both ends use identical CRC math.
- The one natural sub-module is crc8_update: combinational next-CRC from the current CRC and a data byte. It is instantiated here and reusable in the receiver.

Test Plan:
1. Send payload 01,02,10 with in_last on 10.
   - Outputs: 7E(sof,crc 00), 01(crc 07), 02(crc 1B), 10(crc 31), 31(eof, crc 31), then 4 idle cycles.
2. Send a single byte 01 with last.
   - Outputs: 7E, 01(crc 07), 07(eof). tx_busy high for 7 cycles total.
3. Drop in_valid for 2 cycles between 01 and 02 of scenario 1.
   - Two frame_valid=0 bubbles appear, with crc_out held at 07.
   - Final FCS is still 31.
4. MAX_LEN=4: send 6 bytes 00..05 with last on 05.
   - Frame A: 4 bytes, err_oversize pulses with byte 03, FCS follows.
   - Frame B: 7E, 04, 05, FCS, starting after the gap.
5. Hold in_valid high continuously across two 1-byte frames.
   - Exactly IFG_CYCLES+1 frame_valid=0 cycles separate the first FCS from the second SOF.
6. Assert reset low during the DATA byte 02 of scenario 1.
   - All outputs go to 0 asynchronously.
   - After release, a new frame 01 produces 7E, 01(crc 07), 07 with no residual CRC.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared definitions for the frame transmitter/receiver pair: CRC-8 math, delimiter, FSM states.
package frame_pkg;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;
    localparam logic [7:0] SOF_BYTE  = 8'h7E;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SOF  = 3'd1,
        ST_DATA = 3'd2,
        ST_FCS  = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    // One registered output beat towards the receiver
    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       sof;
        logic       eof;
        logic [7:0] crc;
        logic       err;
    } tx_beat_t;

    // CRC-8, MSB first, no reflection, no final XOR
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc8_update.sv
// Combinational next-CRC for one data byte; shared by both ends of the link.
module crc8_update
    import frame_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    output logic [7:0] crc_next_c
);

    // Single-byte CRC step
    assign crc_next_c = crc8_byte(crc_in, data_in);

endmodule

// File: rtl/frame_transmitter.sv
// Frames producer bytes as SOF, payload, FCS with running CRC-8 and an enforced inter-frame gap.
module frame_transmitter #(
    parameter logic [7:0]  SOF_BYTE   = frame_pkg::SOF_BYTE,
    parameter int unsigned MAX_LEN    = 64,
    parameter int unsigned IFG_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] frame_data,
    output logic       frame_valid,
    output logic       frame_sof,
    output logic       frame_eof,
    output logic [7:0] crc_out,
    output logic       err_oversize,
    output logic       tx_busy
);
    import frame_pkg::*;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned GAP_W = 4;

    state_t            state_q, state_d;
    tx_beat_t          beat_q, beat_d;
    logic [7:0]        crc_q, crc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              busy_q, busy_d;
    logic [7:0]        crc_upd_c;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic              xfer_c;

    crc8_update u_crc (
        .crc_in     (crc_q),
        .data_in    (in_data),
        .crc_next_c (crc_upd_c)
    );

    // Ready only while collecting payload; independent of in_valid
    assign in_ready  = (state_q == ST_DATA);
    assign xfer_c    = in_valid && in_ready;
    assign cnt_inc_c = cnt_q + CNT_W'(1);

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state, datapath and output-beat decode
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        beat_d.valid = 1'b0;
        beat_d.sof   = 1'b0;
        beat_d.eof   = 1'b0;
        beat_d.err   = 1'b0;
        crc_d        = crc_q;
        cnt_d        = cnt_q;
        gap_d        = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) state_d = ST_SOF;
            end
            ST_SOF: begin
                beat_d.data  = SOF_BYTE;
                beat_d.valid = 1'b1;
                beat_d.sof   = 1'b1;
                beat_d.crc   = CRC8_INIT;
                crc_d        = CRC8_INIT;
                cnt_d        = '0;
                state_d      = ST_DATA;
            end
            ST_DATA: begin
                if (xfer_c) begin
                    beat_d.data  = in_data;
                    beat_d.valid = 1'b1;
                    beat_d.crc   = crc_upd_c;
                    crc_d        = crc_upd_c;
                    cnt_d        = cnt_inc_c;
                    if (in_last || (cnt_inc_c == CNT_W'(MAX_LEN))) state_d = ST_FCS;
                    if (!in_last && (cnt_inc_c == CNT_W'(MAX_LEN))) beat_d.err = 1'b1;
                end
            end
            ST_FCS: begin
                beat_d.data  = crc_q;
                beat_d.valid = 1'b1;
                beat_d.eof   = 1'b1;
                beat_d.crc   = crc_q;
                gap_d        = GAP_W'(IFG_CYCLES);
                state_d      = ST_GAP;
            end
            ST_GAP: begin
                gap_d = gap_q - GAP_W'(1);
                if (gap_q <= GAP_W'(1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_q <= '0;
            crc_q  <= CRC8_INIT;
            cnt_q  <= '0;
            gap_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            beat_q <= beat_d;
            crc_q  <= crc_d;
            cnt_q  <= cnt_d;
            gap_q  <= gap_d;
            busy_q <= busy_d;
        end
    end

    assign frame_data   = beat_q.data;
    assign frame_valid  = beat_q.valid;
    assign frame_sof    = beat_q.sof;
    assign frame_eof    = beat_q.eof;
    assign crc_out      = beat_q.crc;
    assign err_oversize = beat_q.err;
    assign tx_busy      = busy_q;

endmodule

// File: tb/tb_frame_transmitter.sv
// Directed bench for frame_transmitter with a transaction-level frame model and per-cycle compare.
module tb_frame_transmitter;

    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned IFG     = 4;

    typedef logic [7:0] u8_t;
    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eof;
        logic       err;
        logic [7:0] crc;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] frame_data;
    logic       frame_valid;
    logic       frame_sof;
    logic       frame_eof;
    logic [7:0] crc_out;
    logic       err_oversize;
    logic       tx_busy;

    int n_checks = 0;
    int n_err    = 0;
    beat_t exp_q[$];
    beat_t log_q[$];
    int busy_cnt = 0;
    int idle_run = 0;
    int last_gap = -1;
    bit eof_seen = 0;

    always #5 clk = ~clk;

    frame_transmitter #(
        .SOF_BYTE   (8'h7E),
        .MAX_LEN    (MAX_LEN),
        .IFG_CYCLES (IFG)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .frame_data   (frame_data),
        .frame_valid  (frame_valid),
        .frame_sof    (frame_sof),
        .frame_eof    (frame_eof),
        .crc_out      (crc_out),
        .err_oversize (err_oversize),
        .tx_busy      (tx_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // CRC-8 as polynomial remainder of (crc^data)*x^8 modulo x^8+x^2+x+1
    function automatic u8_t m_crc8(input u8_t crc, input u8_t data);
        logic [15:0] v;
        v = {crc ^ data, 8'h00};
        for (int i = 15; i >= 8; i--) begin
            if (v[i]) v = v ^ (16'h0107 << (i - 8));
        end
        return v[7:0];
    endfunction

    // Expected beat stream for one producer frame, split into MAX_LEN chunks
    task automatic model_frame(input u8_t b[$]);
        int  n;
        u8_t crc;
        bit  last;
        n   = 0;
        crc = 8'h00;
        for (int i = 0; i < b.size(); i++) begin
            if (n == 0) begin
                exp_q.push_back('{8'h7E, 1'b1, 1'b0, 1'b0, 8'h00});
                crc = 8'h00;
            end
            crc  = m_crc8(crc, b[i]);
            n++;
            last = (i == b.size() - 1);
            exp_q.push_back('{b[i], 1'b0, 1'b0, (n == MAX_LEN) && !last, crc});
            if (last || n == MAX_LEN) begin
                exp_q.push_back('{crc, 1'b0, 1'b1, 1'b0, crc});
                n = 0;
            end
        end
    endtask

    // Per-cycle output checker
    task automatic monitor();
        beat_t obs;
        beat_t e;
        forever begin
            @(negedge clk);
            if (frame_valid) begin
                obs = '{frame_data, frame_sof, frame_eof, err_oversize, crc_out};
                log_q.push_back(obs);
                if (frame_sof && eof_seen) begin
                    last_gap = idle_run;
                    eof_seen = 0;
                end
                if (frame_eof) begin
                    eof_seen = 1;
                    idle_run = 0;
                end
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(obs), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 32'(obs), 32'(e));
                end
            end else begin
                idle_run++;
                chk("idle_flags", {29'd0, frame_sof, frame_eof, err_oversize}, 32'd0);
            end
            if (tx_busy) busy_cnt++;
        end
    endtask

    // Present one byte and hold it until accepted; in_valid stays high on return
    task automatic send_byte(input u8_t d, input bit last);
        bit ok;
        int budget;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        budget   = 40;
        ok       = 1'b0;
        while (!ok && budget > 0) begin
            ok = in_ready;
            @(posedge clk);
            #1;
            budget--;
        end
        chk("handshake", {31'd0, ok}, 32'd1);
    endtask

    task automatic send_frame(input u8_t b[$]);
        for (int i = 0; i < b.size(); i++) send_byte(b[i], i == b.size() - 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clk);
            #1;
            if (!tx_busy && exp_q.size() == 0) done = 1'b1;
        end
        chk("drain", {31'd0, done}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_log(input string name, input int idx, input beat_t exp);
        beat_t got;
        got = (idx < log_q.size()) ? log_q[idx] : '0;
        chk(name, 32'(got), 32'(exp));
    endtask

    initial begin
        u8_t q[$];
        reset    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        in_last  = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {frame_data, frame_valid, frame_sof, frame_eof, crc_out,
                              err_oversize, tx_busy, in_ready}, 32'd0);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;

        // 1: three-byte frame
        log_q.delete();
        q.delete(); q.push_back(8'h01); q.push_back(8'h02); q.push_back(8'h10);
        model_frame(q);
        send_frame(q);
        wait_idle();
        chk("s1_len", log_q.size(), 5);
        chk_log("s1_sof", 0, '{8'h7E, 1'b1, 1'b0, 1'b0, 8'h00});
        chk_log("s1_b1",  2, '{8'h02, 1'b0, 1'b0, 1'b0, 8'h1B});
        chk_log("s1_b2",  3, '{8'h10, 1'b0, 1'b0, 1'b0, 8'h31});
        chk_log("s1_fcs", 4, '{8'h31, 1'b0, 1'b1, 1'b0, 8'h31});

        // 2: single-byte frame and busy duration
        log_q.delete();
        busy_cnt = 0;
        q.delete(); q.push_back(8'h01);
        model_frame(q);
        send_frame(q);
        wait_idle();
        chk("s2_fcs_data", (log_q.size() > 2) ? 32'(log_q[2].d) : 32'hFFFF, 32'h07);
        chk("s2_busy_cycles", busy_cnt, 7);

        // 3: two-cycle bubble between first and second payload byte
        log_q.delete();
        q.delete(); q.push_back(8'h01); q.push_back(8'h02); q.push_back(8'h10);
        model_frame(q);
        send_byte(8'h01, 1'b0);
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("s3_bubble", {23'd0, frame_valid, crc_out}, {23'd0, 1'b0, 8'h07});
        end
        send_byte(8'h02, 1'b0);
        send_byte(8'h10, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_idle();
        chk_log("s3_fcs", 4, '{8'h31, 1'b0, 1'b1, 1'b0, 8'h31});

        // 4: truncation at MAX_LEN, leftover bytes form the next frame
        log_q.delete();
        q.delete();
        for (int i = 0; i < 6; i++) q.push_back(u8_t'(i));
        model_frame(q);
        send_frame(q);
        wait_idle();
        chk("s4_len", log_q.size(), 10);
        chk_log("s4_err",  4, '{8'h03, 1'b0, 1'b0, 1'b1, 8'h48});
        chk_log("s4_fcsA", 5, '{8'h48, 1'b0, 1'b1, 1'b0, 8'h48});
        chk_log("s4_sofB", 6, '{8'h7E, 1'b1, 1'b0, 1'b0, 8'h00});
        chk_log("s4_fcsB", 9, '{8'h4F, 1'b0, 1'b1, 1'b0, 8'h4F});

        // 5: in_valid held across two single-byte frames
        log_q.delete();
        last_gap = -1;
        q.delete(); q.push_back(8'h01); model_frame(q);
        q.delete(); q.push_back(8'h02); model_frame(q);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_idle();
        chk("s5_gap", last_gap, IFG + 1);

        // 6: reset while byte 02 is pending
        log_q.delete();
        exp_q.push_back('{8'h7E, 1'b1, 1'b0, 1'b0, 8'h00});
        exp_q.push_back('{8'h01, 1'b0, 1'b0, 1'b0, 8'h07});
        send_byte(8'h01, 1'b0);
        in_data = 8'h02;
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("s6_async_clear", {frame_data, frame_valid, frame_sof, frame_eof, crc_out,
                               err_oversize, tx_busy, in_ready}, 32'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        chk("s6_no_fcs", log_q.size() + exp_q.size(), 2);
        log_q.delete();
        q.delete(); q.push_back(8'h01);
        model_frame(q);
        send_frame(q);
        wait_idle();
        chk_log("s6_sof", 0, '{8'h7E, 1'b1, 1'b0, 1'b0, 8'h00});
        chk_log("s6_b0",  1, '{8'h01, 1'b0, 1'b0, 1'b0, 8'h07});
        chk_log("s6_fcs", 2, '{8'h07, 1'b0, 1'b1, 1'b0, 8'h07});

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
